axi_cfg_regfile: RTL and testbench

Parametrised AXI4-Lite slave register file, the successor to the fixed four-register config block. It provides C_NUM_RW_REGS software-writable control registers and C_NUM_RO_REGS read-only status registers, and decodes AW and W channels independently. It supports per-byte WSTRB, returns SLVERR on unmapped or read-only write accesses, and emits one-cycle write strobes. It sits between the PS AXI interconnect and the neuromorphic datapath, and drives char select, direct control and debug fields.

---
 rtl/axi_cfg_regfile.sv | 194 +++++++++++++++++++
 tb/tb_axi_cfg_regfile.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi_cfg_regfile.sv
// AXI4-Lite register file: NRW byte-strobed control registers, NRO sampled status
// registers, independent AW/W capture, one-cycle write pulses per control register.
module axi_cfg_rw_lane #(
  parameter int          DW  = 32,
  parameter logic [DW-1:0] RST = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [DW-1:0]   wdata,
  input  logic [DW/8-1:0] wstrb,
  output logic [DW-1:0]   q
);
  logic [DW-1:0] reg_d, reg_q;

  always_comb begin
    reg_d = reg_q;
    if (we)
      for (int b = 0; b < DW/8; b++)
        if (wstrb[b]) reg_d[b*8 +: 8] = wdata[b*8 +: 8];
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) reg_q <= RST;
    else        reg_q <= reg_d;

  assign q = reg_q;
endmodule

module axi_cfg_regfile #(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 9,
  parameter int          C_NUM_RW_REGS      = 4,
  parameter int          C_NUM_RO_REGS      = 2,
  parameter logic [63:0] C_RW_RESET_VALUE   = 64'h0
) (
  input  logic                                          S_AXI_ACLK,
  input  logic                                          S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]                 S_AXI_AWADDR,
  input  logic                                          S_AXI_AWVALID,
  output logic                                          S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]                 S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]               S_AXI_WSTRB,
  input  logic                                          S_AXI_WVALID,
  output logic                                          S_AXI_WREADY,
  output logic [1:0]                                    S_AXI_BRESP,
  output logic                                          S_AXI_BVALID,
  input  logic                                          S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]                 S_AXI_ARADDR,
  input  logic                                          S_AXI_ARVALID,
  output logic                                          S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]                 S_AXI_RDATA,
  output logic [1:0]                                    S_AXI_RRESP,
  output logic                                          S_AXI_RVALID,
  input  logic                                          S_AXI_RREADY,
  output logic [C_NUM_RW_REGS*C_S_AXI_DATA_WIDTH-1:0]   rw_regs,
  input  logic [C_NUM_RO_REGS*C_S_AXI_DATA_WIDTH-1:0]   ro_in,
  output logic [C_NUM_RW_REGS-1:0]                      wr_pulse
);
  localparam int DW  = C_S_AXI_DATA_WIDTH;
  localparam int SW  = DW/8;
  localparam int IW  = C_S_AXI_ADDR_WIDTH-2;
  localparam int NRW = C_NUM_RW_REGS;
  localparam int NRO = C_NUM_RO_REGS;

  logic                          rdy_q;
  logic                          aw_held_d, aw_held_q, w_held_d, w_held_q;
  logic [IW-1:0]                 awidx_d, awidx_q;
  logic [DW-1:0]                 wdata_d, wdata_q;
  logic [SW-1:0]                 wstrb_d, wstrb_q;
  logic                          bvalid_d, bvalid_q, rvalid_d, rvalid_q;
  logic [1:0]                    bresp_d, bresp_q, rresp_d, rresp_q;
  logic [DW-1:0]                 rdata_d, rdata_q;
  logic [NRW-1:0]                wr_pulse_d, wr_pulse_q;
  logic [NRO-1:0][DW-1:0]        ro_q;
  logic [NRW-1:0][DW-1:0]        rw_q;
  logic                          aw_hs, w_hs, ar_hs, commit, w_is_rw;
  logic [IW-1:0]                 widx, ridx;
  logic [DW-1:0]                 w_data_eff;
  logic [SW-1:0]                 w_strb_eff;
  logic                          unused_addr_lsbs;

  assign unused_addr_lsbs = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // READY signals come from flops only; rdy_q keeps them low during and just after reset.
  assign S_AXI_AWREADY = rdy_q & ~aw_held_q & ~bvalid_q;
  assign S_AXI_WREADY  = rdy_q & ~w_held_q & ~bvalid_q;
  assign S_AXI_ARREADY = rdy_q & ~rvalid_q;

  assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID & S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;
  assign ridx  = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

  always_comb begin
    widx       = aw_held_q ? awidx_q : S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    w_data_eff = w_held_q ? wdata_q : S_AXI_WDATA;
    w_strb_eff = w_held_q ? wstrb_q : S_AXI_WSTRB;
    commit     = (aw_held_q | aw_hs) & (w_held_q | w_hs) & ~bvalid_q;
    w_is_rw    = int'(widx) < NRW;

    awidx_d   = aw_hs ? S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2] : awidx_q;
    wdata_d   = w_hs ? S_AXI_WDATA : wdata_q;
    wstrb_d   = w_hs ? S_AXI_WSTRB : wstrb_q;
    aw_held_d = aw_held_q | aw_hs;
    w_held_d  = w_held_q | w_hs;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    if (bvalid_q & S_AXI_BREADY) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b0;
    end
    if (commit) begin
      bvalid_d = 1'b1;
      bresp_d  = w_is_rw ? 2'b00 : 2'b10;
    end
    for (int i = 0; i < NRW; i++)
      wr_pulse_d[i] = commit & (int'(widx) == i);
  end

  // Registers update on the same edge the read samples them, so a coincident read sees the old value.
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (rvalid_q & S_AXI_RREADY) rvalid_d = 1'b0;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = '0;
      rresp_d  = 2'b10;
      for (int i = 0; i < NRW; i++)
        if (int'(ridx) == i) begin
          rdata_d = rw_q[i];
          rresp_d = 2'b00;
        end
      for (int i = 0; i < NRO; i++)
        if (int'(ridx) == NRW + i) begin
          rdata_d = ro_q[i];
          rresp_d = 2'b00;
        end
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
    if (!S_AXI_ARESETN) begin
      rdy_q      <= 1'b0;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awidx_q    <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
      rvalid_q   <= 1'b0;
      rresp_q    <= 2'b00;
      rdata_q    <= '0;
      wr_pulse_q <= '0;
      ro_q       <= '0;
    end else begin
      rdy_q      <= 1'b1;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      awidx_q    <= awidx_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
      wr_pulse_q <= wr_pulse_d;
      ro_q       <= ro_in;
    end

  for (genvar g = 0; g < NRW; g++) begin : g_rw
    axi_cfg_rw_lane #(.DW(DW), .RST(C_RW_RESET_VALUE[DW-1:0])) u_lane (
      .clk   (S_AXI_ACLK),
      .rst_n (S_AXI_ARESETN),
      .we    (wr_pulse_d[g] & w_is_rw),
      .wdata (w_data_eff),
      .wstrb (w_strb_eff),
      .q     (rw_q[g])
    );
  end

  assign S_AXI_BVALID = bvalid_q;
  assign S_AXI_BRESP  = bresp_q;
  assign S_AXI_RVALID = rvalid_q;
  assign S_AXI_RRESP  = rresp_q;
  assign S_AXI_RDATA  = rdata_q;
  assign wr_pulse     = wr_pulse_q;
  assign rw_regs      = rw_q;
endmodule

// File: tb/tb_axi_cfg_regfile.sv
// Directed and model-checked bench for axi_cfg_regfile (32-bit data, 4 RW, 2 RO, reset 0xA5).
module tb_axi_cfg_regfile;
  localparam int DW = 32, AW = 9, NRW = 4, NRO = 2;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic [DW-1:0] wdata = '0;
  logic [DW/8-1:0] wstrb = '0;
  logic awready, wready, bvalid, arready, rvalid;
  logic [1:0] bresp, rresp;
  logic [DW-1:0] rdata;
  logic [NRW*DW-1:0] rw_regs;
  logic [NRO*DW-1:0] ro_in = '0;
  logic [NRW-1:0] wr_pulse;

  axi_cfg_regfile #(.C_S_AXI_DATA_WIDTH(DW), .C_S_AXI_ADDR_WIDTH(AW), .C_NUM_RW_REGS(NRW),
                    .C_NUM_RO_REGS(NRO), .C_RW_RESET_VALUE(64'hA5)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .rw_regs(rw_regs), .ro_in(ro_in), .wr_pulse(wr_pulse));

  int n_cmp = 0, n_err = 0;
  logic [31:0] mdl [NRW];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] v = old;
    for (int b = 0; b < 4; b++) if (s[b]) v[b*8 +: 8] = d[b*8 +: 8];
    return v;
  endfunction

  task automatic send_aw(input logic [AW-1:0] a);
    awaddr = a; awvalid = 1;
    for (int k = 0; k < 20 && !awready; k++) step();
    chk("awready", awready, 1);
    step(); awvalid = 0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    wdata = d; wstrb = s; wvalid = 1;
    for (int k = 0; k < 20 && !wready; k++) step();
    chk("wready", wready, 1);
    step(); wvalid = 0;
  endtask

  task automatic send_aw_w(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
    awaddr = a; awvalid = 1; wdata = d; wstrb = s; wvalid = 1;
    for (int k = 0; k < 20 && !(awready && wready); k++) step();
    chk("aw_w_ready", {awready, wready}, 2'b11);
    step(); awvalid = 0; wvalid = 0;
  endtask

  task automatic wait_b(input int dly, output logic [1:0] r);
    for (int k = 0; k < 20 && !bvalid; k++) step();
    chk("bvalid", bvalid, 1);
    for (int k = 0; k < dly; k++) begin step(); chk("bvalid_hold", bvalid, 1); end
    r = bresp; bready = 1; step(); bready = 0;
    chk("bvalid_clr", bvalid, 0);
  endtask

  task automatic axi_rd(input logic [AW-1:0] a, input int dly, output logic [31:0] d, output logic [1:0] r);
    araddr = a; arvalid = 1;
    for (int k = 0; k < 20 && !arready; k++) step();
    chk("arready", arready, 1);
    step(); arvalid = 0;
    chk("rvalid", rvalid, 1);
    for (int k = 0; k < dly; k++) begin step(); chk("arready_low", arready, 0); end
    d = rdata; r = rresp; rready = 1; step(); rready = 0;
    chk("rvalid_clr", rvalid, 0);
  endtask

  initial begin
    logic [1:0] r;
    logic [31:0] d;
    // reset state
    repeat (3) step();
    chk("rst_regs", rw_regs, {4{32'h000000A5}});
    chk("rst_rdy", {awready, wready, arready}, 3'b000);
    chk("rst_vld", {bvalid, rvalid}, 2'b00);
    chk("rst_pulse", wr_pulse, 0);
    rst_n = 1; step();

    // AW first, W three cycles later
    awaddr = 9'h08; awvalid = 1;
    chk("aw_rdy0", awready, 1);
    step(); awvalid = 0;
    for (int k = 1; k <= 3; k++) begin chk("aw_low", awready, 0); if (k < 3) step(); end
    wdata = 32'h1234_5678; wstrb = 4'hF; wvalid = 1;
    chk("w_rdy", wready, 1);
    step(); wvalid = 0;
    chk("c4_bvalid", bvalid, 1);
    chk("c4_reg2", rw_regs[2*32 +: 32], 32'h1234_5678);
    chk("c4_pulse", wr_pulse, 4'b0100);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("hold_b", {bvalid, bresp}, 3'b100);
      chk("pulse_off", wr_pulse, 0);
    end
    bready = 1; step(); bready = 0;
    chk("b_clr", bvalid, 0);
    chk("aw_back", {awready, wready}, 2'b11);

    // byte strobes, W before AW
    send_aw_w(9'h00, 32'h0, 4'hF); wait_b(0, r);
    chk("reg0_zero", rw_regs[31:0], 32'h0);
    send_w(32'hFFFF_FFFF, 4'h2); send_aw(9'h00);
    chk("wfirst_pulse", wr_pulse, 4'b0001);
    wait_b(0, r);
    chk("wfirst_resp", r, 2'b00);
    chk("strb2", rw_regs[31:0], 32'h0000_FF00);
    send_aw(9'h00); send_w(32'h5555_5555, 4'h0);
    chk("strb0_pulse", wr_pulse, 4'b0001);
    wait_b(1, r);
    chk("strb0_resp", r, 2'b00);
    chk("strb0_reg", rw_regs[31:0], 32'h0000_FF00);

    // RO and unmapped writes
    send_aw_w(9'h10, 32'hAAAA_AAAA, 4'hF);
    chk("ro_pulse", wr_pulse, 0);
    wait_b(0, r);
    chk("ro_resp", r, 2'b10);
    send_aw_w(9'h1FC, 32'hBBBB_BBBB, 4'hF);
    chk("um_pulse", wr_pulse, 0);
    wait_b(0, r);
    chk("um_resp", r, 2'b10);
    chk("err_regs", rw_regs, {32'hA5, 32'h1234_5678, 32'hA5, 32'h0000_FF00});
    axi_rd(9'h1FC, 0, d, r);
    chk("um_rdata", d, 0); chk("um_rresp", r, 2'b10);

    // RO sample latency and read hold
    ro_in[31:0] = 32'hDEAD_BEEF; step();
    araddr = 9'h10; arvalid = 1;
    chk("ar_rdy", arready, 1);
    step(); arvalid = 0;
    chk("ro_rvalid", rvalid, 1);
    chk("ro_rdata", rdata, 32'hDEAD_BEEF);
    chk("ro_rresp", rresp, 2'b00);
    ro_in[31:0] = 32'h0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("r_hold", {rvalid, rdata, rresp}, {1'b1, 32'hDEAD_BEEF, 2'b00});
      chk("ar_low", arready, 0);
    end
    rready = 1; step(); rready = 0;
    chk("r_clr", rvalid, 0);
    ro_in[63:32] = 32'h0000_1111;
    step();
    axi_rd(9'h14, 0, d, r);
    chk("ro1_rdata", d, 32'h0000_1111);

    // read coinciding with a commit sees the old value
    send_aw_w(9'h04, 32'h1, 4'hF); wait_b(0, r);
    send_aw(9'h04);
    wdata = 32'h2; wstrb = 4'hF; wvalid = 1; araddr = 9'h04; arvalid = 1;
    chk("coin_rdy", {wready, arready}, 2'b11);
    step(); wvalid = 0; arvalid = 0;
    chk("coin_rdata", rdata, 32'h1);
    chk("coin_reg1", rw_regs[63:32], 32'h2);
    rready = 1; step(); rready = 0;
    wait_b(0, r);
    axi_rd(9'h04, 0, d, r);
    chk("after_rdata", d, 32'h2);

    // async reset during BVALID
    send_aw_w(9'h0C, 32'h7777_7777, 4'hF);
    chk("pre_rst_b", bvalid, 1);
    #2 rst_n = 0; #1;
    chk("async_b", bvalid, 0);
    chk("async_regs", rw_regs, {4{32'h000000A5}});
    chk("async_rdy", {awready, wready, arready}, 3'b000);
    step(); rst_n = 1;
    repeat (3) step();
    chk("post_rst_b", bvalid, 0);

    // random traffic against a model
    for (int i = 0; i < NRW; i++) mdl[i] = 32'hA5;
    ro_in = {32'h0BAD_0002, 32'hCAFE_0001};
    for (int it = 0; it < 40; it++) begin
      int idx;
      logic [31:0] v, exp_d;
      logic [3:0] s;
      logic [1:0] exp_r;
      idx = ($urandom_range(0, 9) == 0) ? 127 : int'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) begin
        v = $urandom; s = 4'($urandom_range(0, 15));
        case ($urandom_range(0, 2))
          0: begin send_aw(9'(idx*4)); repeat ($urandom_range(0, 3)) step(); send_w(v, s); end
          1: begin send_w(v, s); repeat ($urandom_range(0, 3)) step(); send_aw(9'(idx*4)); end
          default: send_aw_w(9'(idx*4), v, s);
        endcase
        exp_r = (idx < NRW) ? 2'b00 : 2'b10;
        if (idx < NRW) mdl[idx] = merge(mdl[idx], v, s);
        wait_b(int'($urandom_range(0, 3)), r);
        chk("rnd_bresp", r, exp_r);
        chk("rnd_regs", rw_regs, {mdl[3], mdl[2], mdl[1], mdl[0]});
      end else begin
        axi_rd(9'(idx*4), int'($urandom_range(0, 3)), d, r);
        if (idx < NRW) exp_d = mdl[idx];
        else if (idx == 4) exp_d = 32'hCAFE_0001;
        else if (idx == 5) exp_d = 32'h0BAD_0002;
        else exp_d = 32'h0;
        exp_r = (idx < NRW + NRO) ? 2'b00 : 2'b10;
        chk("rnd_rdata", d, exp_d);
        chk("rnd_rresp", r, exp_r);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
